// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM states,
// default width and operand magnitude conditioning.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // value arrives already extended to MAX_WIDTH (sign-extended when is_signed);
  // truncating the result to the operand width yields 2^(W-1) for the most negative input.
  function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] value,
                                                   input logic                 is_signed);
    return (is_signed && value[MAX_WIDTH-1]) ? (~value + MAX_WIDTH'(1)) : value;
  endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Sequential shift-add multiplier: one multiplier bit per clock, unsigned or
// two's-complement operands, valid/ready handshakes on both sides.
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e          state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    product_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_next;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    a_mag    = WIDTH'(abs_val(signed_mode ? MAX_WIDTH'($signed(a)) : MAX_WIDTH'(a), signed_mode));
    b_mag    = WIDTH'(abs_val(signed_mode ? MAX_WIDTH'($signed(b)) : MAX_WIDTH'(b), signed_mode));
    acc_next = acc + (mplier[0] ? (PW'(mcand) << cnt) : '0);
  end

  // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else if (clear) begin
      // Abort keeps the last delivered product visible.
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            product_q <= neg ? (~acc_next + PW'(1)) : acc_next;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_mult_core.sv
// Directed and table-driven checks of seq_mult_core at WIDTH=8, plus a
// reference-model sweep over WIDTH=4 and WIDTH=16 instances.
module tb_seq_mult_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic sm = 1'b0;

  logic [7:0]  a8 = '0, b8 = '0;
  logic        iv8 = 1'b0, or8 = 1'b0, ir8, ov8, busy8;
  logic [15:0] prod8;

  logic [3:0]  a4 = '0, b4 = '0;
  logic        iv4 = 1'b0, or4 = 1'b0, ir4, ov4, busy4;
  logic [7:0]  prod4;

  logic [15:0] a16 = '0, b16 = '0;
  logic        iv16 = 1'b0, or16 = 1'b0, ir16, ov16, busy16;
  logic [31:0] prod16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_mult_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .signed_mode(sm), .out_valid(ov8), .out_ready(or8),
    .product(prod8), .busy(busy8));

  seq_mult_core #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .signed_mode(sm), .out_valid(ov4), .out_ready(or4),
    .product(prod4), .busy(busy4));

  seq_mult_core #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .signed_mode(sm), .out_valid(ov16), .out_ready(or16),
    .product(prod16), .busy(busy16));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_ir(input int w);
    case (w)
      4:       return ir4;
      16:      return ir16;
      default: return ir8;
    endcase
  endfunction

  function automatic logic get_ov(input int w);
    case (w)
      4:       return ov4;
      16:      return ov16;
      default: return ov8;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      4:       return busy4;
      16:      return busy16;
      default: return busy8;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int w);
    case (w)
      4:       return {24'b0, prod4};
      16:      return prod16;
      default: return {16'b0, prod8};
    endcase
  endfunction

  task automatic set_in(input int w, input logic [15:0] av, input logic [15:0] bv, input logic v);
    case (w)
      4:       begin a4 = av[3:0]; b4 = bv[3:0]; iv4 = v; end
      16:      begin a16 = av; b16 = bv; iv16 = v; end
      default: begin a8 = av[7:0]; b8 = bv[7:0]; iv8 = v; end
    endcase
  endtask

  task automatic set_or(input int w, input logic v);
    case (w)
      4:       or4 = v;
      16:      or16 = v;
      default: or8 = v;
    endcase
  endtask

  function automatic logic [31:0] ref_mult(input int w, input logic [15:0] av,
                                          input logic [15:0] bv, input logic smv);
    longint x, y, p;
    x = longint'(av) & ((longint'(1) << w) - 1);
    y = longint'(bv) & ((longint'(1) << w) - 1);
    if (smv && x[w-1]) x = x - (longint'(1) << w);
    if (smv && y[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Full job: accept, count cycles to out_valid, then deliver.
  task automatic run_job(input int w, input logic [15:0] av, input logic [15:0] bv,
                         input logic smv, output logic [31:0] prod,
                         output int lat, output int busy_n);
    int guard;
    guard = 0;
    while (!get_ir(w) && guard < 64) begin
      @(posedge clk); #1; guard++;
    end
    sm = smv;
    set_in(w, av, bv, 1'b1);
    @(posedge clk); #1;
    set_in(w, 16'hA5A5, 16'h5A5A, 1'b0);
    sm = ~smv;
    lat = 0;
    busy_n = 0;
    while (!get_ov(w) && lat < 64) begin
      if (get_busy(w)) busy_n++;
      @(posedge clk); #1; lat++;
    end
    prod = get_prod(w);
    set_or(w, 1'b1);
    @(posedge clk); #1;
    set_or(w, 1'b0);
    sm = 1'b0;
  endtask

  task automatic wait_ov8(input string name);
    int guard;
    guard = 0;
    while (!ov8 && guard < 64) begin
      @(posedge clk); #1; guard++;
    end
    if (!ov8) check({name, "_timeout"}, 32'(ov8), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prod;
    int lat, busy_n, seen;
    logic [15:0] av, bv;
    logic smv;

    vecs[0] = '{a: 8'hFF, b: 8'hFF, sm: 1'b0, exp: 16'hFE01};
    vecs[1] = '{a: 8'h80, b: 8'h80, sm: 1'b1, exp: 16'h4000};
    vecs[2] = '{a: 8'h80, b: 8'h01, sm: 1'b1, exp: 16'hFF80};
    vecs[3] = '{a: 8'hFD, b: 8'h05, sm: 1'b1, exp: 16'hFFF1};
    vecs[4] = '{a: 8'h07, b: 8'hFF, sm: 1'b1, exp: 16'hFFF9};
    vecs[5] = '{a: 8'h00, b: 8'h00, sm: 1'b0, exp: 16'h0000};
    vecs[6] = '{a: 8'hFF, b: 8'hFF, sm: 1'b1, exp: 16'h0001};
    vecs[7] = '{a: 8'h7F, b: 8'h80, sm: 1'b1, exp: 16'hC080};
    vecs[8] = '{a: 8'h80, b: 8'h80, sm: 1'b0, exp: 16'h4000};
    vecs[9] = '{a: 8'hFF, b: 8'h01, sm: 1'b0, exp: 16'h00FF};

    // Reset state
    #12;
    check("rst_in_ready", 32'(ir8), 32'd1);
    check("rst_out_valid", 32'(ov8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_product", 32'(prod8), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven WIDTH=8 vectors
    foreach (vecs[i]) begin
      run_job(8, 16'(vecs[i].a), 16'(vecs[i].b), vecs[i].sm, prod, lat, busy_n);
      check($sformatf("vec%0d_product", i), prod, 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd8);
    end

    // Backpressure in DONE with a pending new request
    sm = 1'b0; a8 = 8'h12; b8 = 8'h34; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    wait_ov8("bp_first");
    check("bp_first_product", 32'(prod8), 32'h03A8);
    a8 = 8'h0A; b8 = 8'h0B; iv8 = 1'b1; or8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_in_ready", i), 32'(ir8), 32'd0);
      check($sformatf("bp_hold%0d_out_valid", i), 32'(ov8), 32'd1);
      check($sformatf("bp_hold%0d_product", i), 32'(prod8), 32'h03A8);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check("bp_release_in_ready", 32'(ir8), 32'd1);
    check("bp_release_out_valid", 32'(ov8), 32'd0);
    check("bp_release_product_kept", 32'(prod8), 32'h03A8);
    @(posedge clk); #1;
    iv8 = 1'b0;
    check("bp_next_accept_busy", 32'(busy8), 32'd1);
    wait_ov8("bp_second");
    check("bp_second_product", 32'(prod8), 32'h006E);
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;

    // Clear while RUN with counter at 3
    a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_in_ready", 32'(ir8), 32'd1);
    check("clr_busy", 32'(busy8), 32'd0);
    check("clr_out_valid", 32'(ov8), 32'd0);
    check("clr_product_kept", 32'(prod8), 32'h006E);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov8) seen++;
    end
    check("clr_no_out_valid", 32'(seen), 32'd0);
    run_job(8, 16'd3, 16'd4, 1'b0, prod, lat, busy_n);
    check("clr_after_product", prod, 32'h000C);
    check("clr_after_latency", 32'(lat), 32'd8);

    // Asynchronous reset between edges during RUN
    a8 = 8'h77; b8 = 8'h99; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(ir8), 32'd1);
    check("arst_out_valid", 32'(ov8), 32'd0);
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_product", 32'(prod8), 32'd0);
    #3 rst_n = 1'b1;
    run_job(8, 16'h0000, 16'h0055, 1'b0, prod, lat, busy_n);
    check("arst_after_product", prod, 32'h0000);
    check("arst_after_latency", 32'(lat), 32'd8);

    // Parameter sweep against the reference model
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin av = 16'h8; bv = 16'h8; smv = 1'b1; end
      else begin
        av = 16'($urandom_range(0, 15)); bv = 16'($urandom_range(0, 15)); smv = i[0];
      end
      run_job(4, av, bv, smv, prod, lat, busy_n);
      check($sformatf("w4_%0d_product a=%0h b=%0h s=%0d", i, av, bv, smv), prod,
            ref_mult(4, av, bv, smv));
      check($sformatf("w4_%0d_latency", i), 32'(lat), 32'd4);
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin av = 16'h8000; bv = 16'h8000; smv = 1'b1; end
      else begin
        av = 16'($urandom_range(0, 65535)); bv = 16'($urandom_range(0, 65535)); smv = i[0];
      end
      run_job(16, av, bv, smv, prod, lat, busy_n);
      check($sformatf("w16_%0d_product a=%0h b=%0h s=%0d", i, av, bv, smv), prod,
            ref_mult(16, av, bv, smv));
      check($sformatf("w16_%0d_latency", i), 32'(lat), 32'd16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mult_core.md
Name: seq_mult_core

Overview:
Parametrised sequential shift-add multiplier, the multi-cycle successor to our single-cycle 4x4 combinational multiplier. Accepts WIDTH-bit operands over a valid/ready handshake and computes one multiplier bit per clock. Supports unsigned and two's-complement signed modes, and returns a 2*WIDTH-bit product over a second valid/ready handshake. A pin-level tt_um wrapper instantiates it and maps ui_in/uio/uo_out onto these ports.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..16; product width is 2*WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous abort; returns the block to IDLE.
in_valid  input  1  operand handshake valid.
in_ready  output  1  operand handshake ready; high only in IDLE.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
signed_mode  input  1  1 = operands and product are two's complement; sampled with the operands.
out_valid  output  1  product handshake valid; high only in DONE.
out_ready  input  1  product handshake ready.
product  output  2*WIDTH  result; stable while out_valid=1.
busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator=0, counter=0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. An edge with in_valid=1 accepts the transfer:
  - latch |a| and |b| (magnitudes when signed_mode=1, raw values otherwise);
  - latch neg = signed_mode & (a[MSB] ^ b[MSB]);
  - accumulator=0, counter=0, go to RUN.
- RUN: each edge processes one multiplier bit:
  - if the current LSB of the multiplier register is 1, add the multiplicand shifted left by counter into the 2*WIDTH accumulator;
  - shift the multiplier right and increment counter.
- RUN exit: on the edge that processes bit WIDTH-1, write product = neg ? -(final accumulator) : final accumulator (2*WIDTH-bit two's complement), then go to DONE.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge. Throughput is one result per WIDTH+2 cycles at minimum (one IDLE cycle between jobs).
- DONE: out_valid=1 and product is held. An edge with out_ready=1 goes to IDLE; product keeps its value until the next DONE entry. in_ready=0 in DONE; no overlap of accept and deliver.
- Width rules: magnitude of the most negative value (e.g. -128 for WIDTH=8) is 2^(WIDTH-1) and fits the unsigned WIDTH-bit register. The product never overflows 2*WIDTH bits in either mode. Counter width is $clog2(WIDTH)+1.
- Operands of 0 still take the full WIDTH cycles; there is no early termination.
- clear=1 on any edge: go to IDLE, out_valid=0, accumulator=0, product unchanged. clear has priority over in_valid and out_ready on the same edge.
- Reset mid-RUN or mid-DONE: immediate return to reset values; no partial result is ever presented.
- Inputs a, b and signed_mode are ignored outside the accepting edge.

Decomposition:
- Shared package seq_mult_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - DEFAULT_WIDTH=8;
  - a function abs_val(value, is_signed) used for operand conditioning.
- No internal sub-module is needed. The tt_um pin-level wrapper is a separate module (WIDTH=4; ui_in carries a/b; uio carries the control signals).

Test Plan:
- Unsigned, WIDTH=8: a=0xFF, b=0xFF, signed_mode=0 -> out_valid exactly 8 cycles after accept; product=0xFE01; busy high for those 8 cycles.
- Signed corners, WIDTH=8: (-128)*(-128) -> 0x4000; (-128)*1 -> 0xFF80; (-3)*5 -> 0xFFF1; 7*(-1) -> 0xFFF9.
- Handshake backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready stays 0 and product stays stable; out_ready=1 -> IDLE next edge, then new operands accepted.
- clear during RUN at counter=3 -> IDLE next edge, out_valid never asserts; a following 3*4 run yields 0x000C.
- Async reset asserted mid-RUN between clock edges -> outputs take reset values immediately; after release, 0*0x55 returns 0x0000 after 8 cycles.
- Parameter sweep WIDTH=4 and WIDTH=16: random signed and unsigned operands checked against a reference model; latency equals WIDTH.
